// File: rtl/axi_slave_ram.sv
// AXI-lite-style slave memory: independent write (AW/W/B) and read (AR/R)
// FSMs in front of a DATA_W-wide on-chip RAM. Out-of-range accesses return an
// error response, write nothing, and read back as zero.
module axi_slave_ram #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int DEPTH_LOG2 = 12,
    parameter int RD_LAT     = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                awvalid,
    output logic                awready,
    input  logic                awid,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                wvalid,
    output logic                wready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic                bvalid,
    input  logic                bready,
    output logic                bresp,
    input  logic                arvalid,
    output logic                arready,
    input  logic [ADDR_W-1:0]   araddr,
    output logic                rvalid,
    input  logic                rready,
    output logic [DATA_W-1:0]   rdata,
    output logic                rresp
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_HI = OFF_W + DEPTH_LOG2;
    localparam logic [2:0] LAT_LOAD = (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;

    typedef enum logic       {W_IDLE, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;

    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

    w_state_e            w_state_q, w_state_d;
    logic                aw_got_q, aw_got_d;
    logic                w_got_q, w_got_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                bresp_q, bresp_d;

    r_state_e            r_state_q, r_state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] ar_idx_q, ar_idx_d;
    logic                ar_err_q, ar_err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rresp_q, rresp_d;

    // Holds the interface quiet for the first cycle out of reset.
    logic                init_q;

    logic                aw_hs, w_hs, ar_hs;
    logic                mem_we;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [STRB_W-1:0]   wr_strb;
    logic                wr_err;
    logic                rd_err_hs;
    logic                unused_ok;

    assign awready = init_q && (w_state_q == W_IDLE) && !aw_got_q;
    assign wready  = init_q && (w_state_q == W_IDLE) && !w_got_q;
    assign arready = init_q && (r_state_q == R_IDLE);
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign ar_hs   = arvalid && arready;

    assign bvalid  = (w_state_q == W_RESP);
    assign bresp   = bvalid && bresp_q;
    assign rvalid  = (r_state_q == R_DATA);
    assign rresp   = rvalid && rresp_q;
    assign rdata   = rdata_q;

    // Payload for the commit comes from the latch if already captured, else from the live bus.
    assign wr_addr   = aw_got_q ? awaddr_q : awaddr;
    assign wr_data   = w_got_q ? wdata_q : wdata;
    assign wr_strb   = w_got_q ? wstrb_q : wstrb;
    assign wr_err    = |wr_addr[ADDR_W-1:IDX_HI];
    assign rd_err_hs = |araddr[ADDR_W-1:IDX_HI];

    assign unused_ok = ^{awid, awaddr_q[OFF_W-1:0], araddr[OFF_W-1:0]};

    // Write channel: latch AW/W in any order, commit once both are present, then hold B.
    always_comb begin
        w_state_d = w_state_q;
        aw_got_d  = aw_got_q;
        w_got_d   = w_got_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bresp_d   = bresp_q;
        mem_we    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_got_d = 1'b1;
                    awaddr_d = awaddr;
                end
                if (w_hs) begin
                    w_got_d = 1'b1;
                    wdata_d = wdata;
                    wstrb_d = wstrb;
                end
                if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) begin
                    mem_we    = rst_n && !wr_err;
                    bresp_d   = wr_err;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (bready) begin
                    w_state_d = W_IDLE;
                    aw_got_d  = 1'b0;
                    w_got_d   = 1'b0;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read channel: capture address, count out the wait, sample RAM on entry to R_DATA.
    always_comb begin
        r_state_d = r_state_q;
        cnt_d     = cnt_q;
        ar_idx_d  = ar_idx_q;
        ar_err_d  = ar_err_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    ar_idx_d = araddr[IDX_HI-1:OFF_W];
                    ar_err_d = rd_err_hs;
                    cnt_d    = LAT_LOAD;
                    if (RD_LAT > 0) begin
                        r_state_d = R_WAIT;
                    end else begin
                        r_state_d = R_DATA;
                        rdata_d   = rd_err_hs ? '0 : mem[araddr[IDX_HI-1:OFF_W]];
                        rresp_d   = rd_err_hs;
                    end
                end
            end
            R_WAIT: begin
                if (cnt_q == 3'd0) begin
                    r_state_d = R_DATA;
                    rdata_d   = ar_err_q ? '0 : mem[ar_idx_q];
                    rresp_d   = ar_err_q;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            R_DATA: begin
                if (rready) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // State and payload registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            init_q    <= 1'b0;
            w_state_q <= W_IDLE;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= 1'b0;
            r_state_q <= R_IDLE;
            cnt_q     <= 3'd0;
            ar_idx_q  <= '0;
            ar_err_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 1'b0;
        end else begin
            init_q    <= 1'b1;
            w_state_q <= w_state_d;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            cnt_q     <= cnt_d;
            ar_idx_q  <= ar_idx_d;
            ar_err_q  <= ar_err_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // RAM array, byte-lane write; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wr_strb[i]) mem[wr_addr[IDX_HI-1:OFF_W]][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi_slave_ram.sv
// Scoreboard bench for axi_slave_ram: expected B/R responses are queued at
// issue and compared by a monitor when the DUT hands them over.
module tb_axi_slave_ram;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int DEPTH_LOG2 = 12;
    localparam int RD_LAT = 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              awvalid, awready, awid;
    logic [ADDR_W-1:0] awaddr;
    logic              wvalid, wready;
    logic [DATA_W-1:0] wdata;
    logic [7:0]        wstrb;
    logic              bvalid, bready, bresp;
    logic              arvalid, arready;
    logic [ADDR_W-1:0] araddr;
    logic              rvalid, rready;
    logic [DATA_W-1:0] rdata;
    logic              rresp;

    int checks = 0;
    int errors = 0;

    logic        wq[$];
    logic [64:0] rq[$];

    always #5 clk = ~clk;

    axi_slave_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2), .RD_LAT(RD_LAT)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Scoreboard side: compare responses at the point they are accepted.
    always @(negedge clk) begin
        if (rst_n && bvalid && bready) begin
            if (wq.size() == 0) chk("b_unexpected", 64'(wq.size()), 64'd1);
            else chk("bresp", {63'd0, bresp}, {63'd0, wq.pop_front()});
        end
        if (rst_n && rvalid && rready) begin
            if (rq.size() == 0) chk("r_unexpected", 64'(rq.size()), 64'd1);
            else begin
                logic [64:0] e;
                e = rq.pop_front();
                chk("rresp", {63'd0, rresp}, {63'd0, e[64]});
                chk("rdata", rdata, e[63:0]);
            end
        end
    end

    task automatic axi_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s, input logic er);
        awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d; wstrb = s;
        wq.push_back(er);
        @(negedge clk);
        chk("awready_idle", {63'd0, awready}, 64'd1);
        chk("wready_idle", {63'd0, wready}, 64'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        chk("bvalid_lat", {63'd0, bvalid}, 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input logic [31:0] a, input logic [63:0] d, input logic er);
        arvalid = 1'b1; araddr = a;
        rq.push_back({er, d});
        @(negedge clk);
        chk("arready_idle", {63'd0, arready}, 64'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        for (int i = 0; i < RD_LAT; i++) begin
            @(negedge clk);
            chk("rvalid_early", {63'd0, rvalid}, 64'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("rvalid_lat", {63'd0, rvalid}, 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; awid = 1'b0;
        awvalid = 1'b0; awaddr = '0; wvalid = 1'b0; wdata = '0; wstrb = '0;
        arvalid = 1'b0; araddr = '0; bready = 1'b1; rready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", {63'd0, awready}, 64'd0);
        chk("rst_wready", {63'd0, wready}, 64'd0);
        chk("rst_arready", {63'd0, arready}, 64'd0);
        chk("rst_bvalid", {63'd0, bvalid}, 64'd0);
        chk("rst_rvalid", {63'd0, rvalid}, 64'd0);
        chk("rst_bresp", {63'd0, bresp}, 64'd0);
        chk("rst_rresp", {63'd0, rresp}, 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("init_awready", {63'd0, awready}, 64'd0);
        @(posedge clk); #1;

        // Basic write then read
        axi_write(32'h10, 64'h1122334455667788, 8'hFF, 1'b0);
        axi_read(32'h10, 64'h1122334455667788, 1'b0);

        // Partial strobe
        axi_write(32'h10, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 1'b0);
        axi_write(32'h10, 64'h0, 8'h0F, 1'b0);
        axi_read(32'h10, 64'hFFFFFFFF00000000, 1'b0);

        // W three cycles ahead of AW, B held off for 4 cycles
        bready = 1'b0;
        wvalid = 1'b1; wdata = 64'hCAFEF00DDEADBEEF; wstrb = 8'hFF;
        @(posedge clk); #1;
        wvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("skew_wready_low", {63'd0, wready}, 64'd0);
            chk("skew_awready_high", {63'd0, awready}, 64'd1);
            chk("skew_bvalid_low", {63'd0, bvalid}, 64'd0);
            @(posedge clk); #1;
        end
        awvalid = 1'b1; awaddr = 32'h48;
        wq.push_back(1'b0);
        @(negedge clk);
        chk("skew_awready_high", {63'd0, awready}, 64'd1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_bvalid_hold", {63'd0, bvalid}, 64'd1);
            chk("bp_awready_low", {63'd0, awready}, 64'd0);
            @(posedge clk); #1;
        end
        bready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_bvalid_clear", {63'd0, bvalid}, 64'd0);
        @(posedge clk); #1;
        axi_read(32'h48, 64'hCAFEF00DDEADBEEF, 1'b0);

        // Out-of-range write must not alias onto word 0
        axi_write(32'h0, 64'h0123456789ABCDEF, 8'hFF, 1'b0);
        axi_write(32'h1 << (3 + DEPTH_LOG2), 64'h5555555555555555, 8'hFF, 1'b1);
        axi_read(32'h1 << (3 + DEPTH_LOG2), 64'h0, 1'b1);
        axi_read(32'h0, 64'h0123456789ABCDEF, 1'b0);

        // Write commits on the same edge the read samples: old data returned
        axi_write(32'h20, 64'hA, 8'hFF, 1'b0);
        arvalid = 1'b1; araddr = 32'h20;
        rq.push_back({1'b0, 64'hA});
        for (int i = 0; i < RD_LAT; i++) begin
            @(posedge clk); #1;
            arvalid = 1'b0;
        end
        awvalid = 1'b1; awaddr = 32'h20; wvalid = 1'b1; wdata = 64'hB; wstrb = 8'hFF;
        wq.push_back(1'b0);
        @(posedge clk); #1;
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        axi_read(32'h20, 64'hB, 1'b0);

        // Reset while both responses are pending
        bready = 1'b0; rready = 1'b0;
        awvalid = 1'b1; awaddr = 32'h30; wvalid = 1'b1; wdata = 64'h3030303030303030; wstrb = 8'hFF;
        arvalid = 1'b1; araddr = 32'h10;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        repeat (RD_LAT) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("pre_rst_bvalid", {63'd0, bvalid}, 64'd1);
        chk("pre_rst_rvalid", {63'd0, rvalid}, 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_bvalid", {63'd0, bvalid}, 64'd0);
        chk("mid_rst_rvalid", {63'd0, rvalid}, 64'd0);
        chk("mid_rst_arready", {63'd0, arready}, 64'd0);
        chk("mid_rst_awready", {63'd0, awready}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_awready", {63'd0, awready}, 64'd0);
        chk("post_rst_wready", {63'd0, wready}, 64'd0);
        chk("post_rst_arready", {63'd0, arready}, 64'd0);
        @(posedge clk); #1;
        bready = 1'b1; rready = 1'b1;
        axi_read(32'h10, 64'hFFFFFFFF00000000, 1'b0);
        axi_read(32'h30, 64'h3030303030303030, 1'b0);

        repeat (2) @(posedge clk);
        chk("wq_drained", 64'(wq.size()), 64'd0);
        chk("rq_drained", 64'(rq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_slave_ram.md
Name: axi_slave_ram

Overview:
- Single-port-per-channel AXI-lite-style slave memory that sits directly downstream of the core's store/load AXI master.
- Consumes the AW/W/B and AR/R channels produced for core data accesses and backs them with an on-chip RAM array.
- Serves as the data memory in simulation and FPGA builds, and as the reference responder for master-side verification.

Parameters:
ADDR_W, 32, byte address width of awaddr/araddr
DATA_W, 64, data bus width; STRB_W = DATA_W/8
DEPTH_LOG2, 12, log2 of RAM depth in DATA_W words
RD_LAT, 1, extra wait cycles between AR handshake and rvalid (0..7)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
awvalid  in  1  write address valid
awready  out  1  write address ready
awid  in  1  write id, echoed nowhere (accepted, ignored)
awaddr  in  ADDR_W  write byte address
wvalid  in  1  write data valid
wready  out  1  write data ready
wdata  in  DATA_W  write data
wstrb  in  STRB_W  byte enables
bvalid  out  1  write response valid
bready  in  1  write response ready
bresp  out  1  0=OKAY, 1=address error
arvalid  in  1  read address valid
arready  out  1  read address ready
araddr  in  ADDR_W  read byte address
rvalid  out  1  read data valid
rready  in  1  read data ready
rdata  out  DATA_W  read data
rresp  out  1  0=OKAY, 1=address error

Behaviour:
- Reset: synchronous; while rst_n=0 at a clk edge, both FSMs go to IDLE, the latch flags clear, and all outputs are 0. The outputs awready, wready, arready, bvalid, rvalid, bresp, rresp and rdata are all 0 during reset and for one cycle after rst_n rises, via a registered init flag. The RAM contents are not reset.
- Word index = addr[log2(STRB_W)+DEPTH_LOG2-1 : log2(STRB_W)]. Low offset bits are ignored.
- An address is in range iff addr[ADDR_W-1 : log2(STRB_W)+DEPTH_LOG2] == 0. Otherwise the access is an error.
- Write FSM states: W_IDLE, W_RESP.
  - In W_IDLE, awready=wready=1. AW and W may arrive in either order or in the same cycle.
  - Each handshake latches its payload plus a flag (aw_got, w_got).
  - The RAM commit happens in the cycle both flags are set, or in the cycle both handshakes complete: the RAM is written on that edge, byte lanes gated by wstrb, and only if the address is in range. The FSM then moves to W_RESP.
  - Once a channel's flag is set, that channel's ready drops to 0 until return to W_IDLE.
  - In W_RESP: bvalid=1, bresp=error bit. bvalid and bresp hold stable until bready=1, then the FSM returns to W_IDLE next cycle with flags cleared.
  - Minimum latency: AW+W handshake cycle N, bvalid asserted cycle N+1.
- Read FSM states: R_IDLE, R_WAIT, R_DATA.
  - R_IDLE: arready=1. On handshake, the address and error bit are latched. The FSM goes to R_WAIT if RD_LAT>0, else to R_DATA. A wait counter is loaded with RD_LAT-1.
  - R_WAIT: the counter decrements each cycle; at 0 the FSM goes to R_DATA.
  - On entry to R_DATA: rdata = RAM[index], or 0 if error; rresp = error bit. rvalid=1.
  - rdata, rresp and rvalid hold stable until rready=1, then the FSM returns to R_IDLE.
  - Latency: AR handshake cycle N, rvalid at cycle N+1+RD_LAT.
- The read and write FSMs are fully independent and may be active concurrently.
- Same-word collision: RAM data is sampled on the edge entering R_DATA. If the write commits on that same edge, the read returns the old data. A write that committed on an earlier edge is visible.
- Valid inputs are not required to be held by the master beyond the handshake. Payloads are captured only at handshake.
- Reset mid-transaction: pending flags, bvalid and rvalid are cleared; no RAM write occurs on the reset edge.

Test Plan:
- Basic write then read: AW+W at 0x10, wdata=0x1122334455667788, wstrb=0xFF, bready=1. Required: bvalid the next cycle with bresp=0. Then AR 0x10 with RD_LAT=1. Required: rvalid 2 cycles after handshake, rdata=0x1122334455667788, rresp=0.
- Partial strobe: preload 0x10 with all-Fs, write wdata=0 with wstrb=0x0F. Required: read returns 0xFFFFFFFF00000000.
- AW/W skew and backpressure: W three cycles before AW, bready held 0 for 4 cycles. Required:
  - wready drops after the W handshake; awready stays 1 until AW arrives.
  - bvalid stays stable at 1 for 4 cycles; bvalid clears one cycle after bready=1.
- Out-of-range: write to 1<<(3+DEPTH_LOG2). Required: bresp=1, RAM unchanged. Read of the same address: rresp=1, rdata=0.
- Concurrent and collision: AR and the completing AW+W to word 0x20 on the same cycle, with RD_LAT=0 and old data 0xA. Required: rdata=0xA. A second read of 0x20 returns the new data.
- Reset mid-op: assert rst_n=0 while bvalid=1 and rvalid=1. Required:
  - bvalid and rvalid are 0 on the next edge.
  - All readies are 0 until one cycle after rst_n=1.
  - Previously committed RAM data is still readable.
